// File: rtl/loop_predictor.sv
// Tagged loop-exit predictor: learns backward-branch trip counts in EX, overrides fetch prediction when confident.
// Optional usage/mispredict counters are compiled in with LOOP_PRED_STATS_EN.
module loop_predictor #(
    parameter int WIDTH     = 32,
    parameter int ENTRIES   = 64,
    parameter int TAG_BITS  = 8,
    parameter int CNT_BITS  = 10,
    parameter int CONF_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_F,
    input  logic             branch_en_F,
    input  logic [WIDTH-1:0] PC_EX,
    input  logic [WIDTH-1:0] PC_destination,
    input  logic             branch_en_EX,
    input  logic             feedback_from_ALU,
    input  logic             clear_req,
    output logic             loop_decision,
    output logic             LD_en,
    output logic             busy
`ifdef LOOP_PRED_STATS_EN
    ,
    output logic [31:0]      stat_used,
    output logic [31:0]      stat_mispred
`endif
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
    localparam logic [CNT_BITS-1:0]  ITER_MAX = '1;
    localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(ENTRIES - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q;
    logic                busy_q;
    logic [IDX_BITS-1:0] ptr_q;

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [CNT_BITS-1:0] iter_q  [ENTRIES];
    logic [CNT_BITS-1:0] trip_q  [ENTRIES];
    logic [CONF_BITS-1:0] conf_q [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, ex_idx;
    logic [TAG_BITS-1:0] f_tag, ex_tag;
    logic                f_hit, ex_hit, train;
    logic                unused_pc_bits;

    assign f_idx  = PC_F[IDX_BITS+1:2];
    assign f_tag  = PC_F[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign ex_idx = PC_EX[IDX_BITS+1:2];
    assign ex_tag = PC_EX[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign unused_pc_bits = ^{PC_F[WIDTH-1:IDX_BITS+TAG_BITS+2], PC_F[1:0],
                              PC_EX[WIDTH-1:IDX_BITS+TAG_BITS+2], PC_EX[1:0]};

    // Prediction reads the table as it stands this cycle; same-cycle EX updates land at the edge.
    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign LD_en  = branch_en_F && f_hit && (conf_q[f_idx] == CONF_MAX) && !busy_q;
    assign loop_decision = LD_en && (iter_q[f_idx] != trip_q[f_idx]);
    assign busy   = busy_q;

    // Only resolved backward branches train, and never during a clear walk.
    assign train  = branch_en_EX && (PC_destination < PC_EX) && !busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                iter_q[i]  <= '0;
                trip_q[i]  <= '0;
                conf_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        ptr_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    valid_q[ptr_q] <= 1'b0;
                    tag_q[ptr_q]   <= '0;
                    iter_q[ptr_q]  <= '0;
                    trip_q[ptr_q]  <= '0;
                    conf_q[ptr_q]  <= '0;
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (train) begin
                if (ex_hit) begin
                    if (feedback_from_ALU) begin
                        // A loop that overflows the iteration counter cannot be tracked.
                        if (iter_q[ex_idx] == ITER_MAX) valid_q[ex_idx] <= 1'b0;
                        else iter_q[ex_idx] <= iter_q[ex_idx] + 1'b1;
                    end else begin
                        if (iter_q[ex_idx] == trip_q[ex_idx]) begin
                            if (conf_q[ex_idx] != CONF_MAX) conf_q[ex_idx] <= conf_q[ex_idx] + 1'b1;
                        end else begin
                            trip_q[ex_idx] <= iter_q[ex_idx];
                            conf_q[ex_idx] <= '0;
                        end
                        iter_q[ex_idx] <= '0;
                    end
                end else if (feedback_from_ALU) begin
                    if (!valid_q[ex_idx] || conf_q[ex_idx] == '0) begin
                        valid_q[ex_idx] <= 1'b1;
                        tag_q[ex_idx]   <= ex_tag;
                        iter_q[ex_idx]  <= CNT_BITS'(1);
                        trip_q[ex_idx]  <= '0;
                        conf_q[ex_idx]  <= '0;
                    end else begin
                        // Confident victims are aged instead of evicted.
                        conf_q[ex_idx] <= conf_q[ex_idx] - 1'b1;
                    end
                end
            end
        end
    end

`ifdef LOOP_PRED_STATS_EN
    logic clear_done, mispred;
    assign clear_done = busy_q && (ptr_q == LAST_IDX);
    assign mispred    = train && ex_hit && (conf_q[ex_idx] == CONF_MAX) &&
                        (feedback_from_ALU != (iter_q[ex_idx] != trip_q[ex_idx]));

    always_ff @(posedge clk) begin
        if (!rst || clear_done) begin
            stat_used    <= '0;
            stat_mispred <= '0;
        end else begin
            if (LD_en && stat_used != '1) stat_used <= stat_used + 1'b1;
            if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_loop_predictor.sv
// Directed bench for loop_predictor: training, confidence, aliasing, forward branches, clear walk and reset abort.
module tb_loop_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_F, PC_EX, PC_destination;
  logic        branch_en_F, branch_en_EX, feedback_from_ALU, clear_req;
  logic        loop_decision, LD_en, busy;
`ifdef LOOP_PRED_STATS_EN
  logic [31:0] stat_used, stat_mispred;
`endif

  int total = 0;
  int bad = 0;

  loop_predictor dut (
    .clk(clk), .rst(rst), .PC_F(PC_F), .branch_en_F(branch_en_F),
    .PC_EX(PC_EX), .PC_destination(PC_destination), .branch_en_EX(branch_en_EX),
    .feedback_from_ALU(feedback_from_ALU), .clear_req(clear_req),
    .loop_decision(loop_decision), .LD_en(LD_en), .busy(busy)
`ifdef LOOP_PRED_STATS_EN
    , .stat_used(stat_used), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] dest, input logic taken);
    branch_en_EX = 1'b1;
    PC_EX = pc;
    PC_destination = dest;
    feedback_from_ALU = taken;
    tick();
    branch_en_EX = 1'b0;
  endtask

  task automatic train_instance(input logic [31:0] pc, input logic [31:0] dest, input int n_taken);
    for (int i = 0; i < n_taken; i++) resolve(pc, dest, 1'b1);
    resolve(pc, dest, 1'b0);
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] pc, input logic exp_ld, input logic exp_dec);
    branch_en_F = 1'b1;
    PC_F = pc;
    #1;
    check({tag, "_ld_en"}, 32'(LD_en), 32'(exp_ld));
    check({tag, "_dec"}, 32'(loop_decision), 32'(exp_dec));
  endtask

  initial begin
    int n;
    rst = 1'b0;
    PC_F = '0; PC_EX = '0; PC_destination = '0;
    branch_en_F = 1'b0; branch_en_EX = 1'b0; feedback_from_ALU = 1'b0; clear_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Reset state
    fetch_check("reset", 32'h100, 1'b0, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);

    // Train loop at 0x100 with trip 3
    train_instance(32'h100, 32'h0F0, 3);
    check("exit1_trip", 32'(dut.trip_q[0]), 32'd3);
    check("exit1_conf", 32'(dut.conf_q[0]), 32'd0);
    fetch_check("exit1", 32'h100, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) train_instance(32'h100, 32'h0F0, 3);
    check("exit4_conf", 32'(dut.conf_q[0]), 32'd3);
    for (int k = 0; k < 3; k++) begin
      fetch_check("inst5_body", 32'h100, 1'b1, 1'b1);
      resolve(32'h100, 32'h0F0, 1'b1);
    end
    fetch_check("inst5_exit", 32'h100, 1'b1, 1'b0);
    resolve(32'h100, 32'h0F0, 1'b0);
    fetch_check("inst6_start", 32'h100, 1'b1, 1'b1);
    branch_en_F = 1'b0;
    #1;
    check("no_branch_f_ld_en", 32'(LD_en), 32'd0);
    check("no_branch_f_dec", 32'(loop_decision), 32'd0);

    // Trip count change drops confidence
    train_instance(32'h100, 32'h0F0, 5);
    check("retrip_trip", 32'(dut.trip_q[0]), 32'd5);
    check("retrip_conf", 32'(dut.conf_q[0]), 32'd0);
    fetch_check("retrip", 32'h100, 1'b0, 1'b0);

    // Alias at 0x500 ages then replaces 0x100
    for (int k = 0; k < 4; k++) train_instance(32'h100, 32'h0F0, 3);
    fetch_check("alias_pre", 32'h100, 1'b1, 1'b1);
    resolve(32'h500, 32'h4F0, 1'b1);
    check("alias1_conf", 32'(dut.conf_q[0]), 32'd2);
    check("alias1_tag", 32'(dut.tag_q[0]), 32'h01);
    fetch_check("alias1_old", 32'h100, 1'b0, 1'b0);
    resolve(32'h500, 32'h4F0, 1'b1);
    resolve(32'h500, 32'h4F0, 1'b1);
    check("alias3_tag", 32'(dut.tag_q[0]), 32'h01);
    resolve(32'h500, 32'h4F0, 1'b1);
    check("alias4_tag", 32'(dut.tag_q[0]), 32'h05);
    check("alias4_iter", 32'(dut.iter_q[0]), 32'd1);
    fetch_check("alias_old_miss", 32'h100, 1'b0, 1'b0);

    // Forward branches never train
    for (int k = 0; k < 10; k++) resolve(32'h204, 32'h300, 1'b1);
    check("fwd_valid", 32'(dut.valid_q[1]), 32'd0);
    fetch_check("fwd", 32'h204, 1'b0, 1'b0);

    // Train 0x500 to full confidence before clearing
    train_instance(32'h500, 32'h4F0, 2);
    for (int k = 0; k < 3; k++) train_instance(32'h500, 32'h4F0, 3);
    fetch_check("pre_clear", 32'h500, 1'b1, 1'b1);

    // Clear walk: 64 busy cycles, EX and repeated clear_req ignored
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    check("clear_ld_gated", 32'(LD_en), 32'd0);
    PC_EX = 32'h208;
    PC_destination = 32'h100;
    feedback_from_ALU = 1'b1;
    n = 1;
    while (busy && n < 200) begin
      branch_en_EX = (n == 5);
      clear_req = (n == 20);
      tick();
      if (busy) n++;
    end
    branch_en_EX = 1'b0;
    clear_req = 1'b0;
    check("clear_cycles", 32'(n), 32'd64);
    check("clear_ex_dropped", 32'(dut.valid_q[2]), 32'd0);
    fetch_check("post_clear", 32'h500, 1'b0, 1'b0);

    // Reset during walk cycle 10 aborts it
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    check("walk_mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    check("walk_abort_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    check("walk_abort_stays_idle", 32'(busy), 32'd0);
    fetch_check("after_abort", 32'h500, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loop_predictor.md
Name: loop_predictor

Overview:
- Parametrised, tagged loop-exit predictor for the branch prediction unit.
- Learns the trip count of backward conditional branches from resolved outcomes in EX.
- At fetch, it supplies a high-confidence taken/not-taken override for the main predictor.
- It adds tags, confidence counters, iteration saturation, victim aging and a walking table-clear FSM.

Parameters:
- WIDTH, 32, PC/address width.
- ENTRIES, 64, table depth; power of two, 4..1024; IDX_BITS = clog2(ENTRIES).
- TAG_BITS, 8, partial tag width.
- CNT_BITS, 10, width of the iteration and trip counters.
- CONF_BITS, 2, width of the confidence counter; CONF_MAX = all ones.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- PC_F  in  WIDTH  fetch PC.
- branch_en_F  in  1  fetch-stage instruction is a conditional branch.
- PC_EX  in  WIDTH  PC of the branch resolving in EX.
- PC_destination  in  WIDTH  resolved target of the EX branch.
- branch_en_EX  in  1  a conditional branch resolves this cycle.
- feedback_from_ALU  in  1  resolved direction (1 = taken).
- clear_req  in  1  single-cycle request to invalidate the whole table.
- loop_decision  out  1  predicted direction.
- LD_en  out  1  prediction valid/confident; main predictor must use loop_decision.
- busy  out  1  clear walk in progress.

Behaviour:
- Indexing: idx = PC[IDX_BITS+1:2]; tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. This applies to both PC_F and PC_EX.
- Entry fields: valid, tag, iter[CNT_BITS], trip[CNT_BITS], conf[CONF_BITS].
- Reset: when rst=0 at a clk edge, all entries are cleared (valid=0, all fields 0) and the FSM goes to IDLE.
  - LD_en=0, loop_decision=0 and busy=0 from that edge.
  - A reset in the middle of a clear walk aborts the walk.
- Prediction (combinational from current table state, zero-cycle latency):
  - hit = valid && tag match, evaluated on PC_F.
  - LD_en = branch_en_F && hit && conf==CONF_MAX && !busy.
  - loop_decision = LD_en && (iter != trip); it is 0 whenever LD_en=0.
- Training (EX) happens only when branch_en_EX=1, PC_destination < PC_EX (unsigned backward branch) and !busy. All other EX events are ignored.
- Hit, taken:
  - If iter == all ones, the entry is invalidated (loop too long).
  - Otherwise iter <= iter+1.
- Hit, not-taken:
  - If iter == trip, conf <= conf+1, saturating at CONF_MAX.
  - Otherwise trip <= iter and conf <= 0.
  - In both cases iter <= 0.
- Miss, taken:
  - If the victim entry is invalid or has conf==0, allocate it: valid=1, new tag, iter=1, trip=0, conf=0.
  - Otherwise age the victim with conf <= conf-1 and do not allocate.
- Miss, not-taken: no table change.
- Same index in F and EX in the same cycle: the prediction uses pre-update state; the update lands at the clock edge.
- Counters are not speculative. Fetches in flight between F and EX see stale iter; this is accepted.
- Clear FSM:
  - IDLE: clear_req=1 goes to CLEAR with ptr=0 and busy=1.
  - CLEAR: invalidate entry[ptr] each cycle, ptr++. After entry ENTRIES-1 is cleared, return to IDLE and drop busy on the next cycle.
  - A clear takes exactly ENTRIES cycles.
  - clear_req while busy is ignored.
  - While busy, EX updates are dropped and LD_en=0.

Optional Feature:
- Macro: LOOP_PRED_STATS_EN.
- When defined, the block adds two output ports, each 32 bits and saturating at all ones:
  - stat_used counts cycles with LD_en=1.
  - stat_mispred counts EX training events on a hit with conf==CONF_MAX whose direction differs from (iter != trip), evaluated with pre-update state.
- Both counters clear on reset and on clear completion.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then PC_F=0x100 with branch_en_F=1 -> LD_en=0, loop_decision=0, busy=0.
- Loop PC_EX=0x100, PC_destination=0x0F0: 3 taken then 1 not-taken, repeated 5 times (defaults, CONF_MAX=3).
  - Exit 1 sets trip=3 with conf=0; exits 2 to 4 bring conf to 3.
  - In the 5th instance, fetch 0x100 -> LD_en=1 with loop_decision=1 while iter=0,1,2, and loop_decision=0 at iter=3.
- Trained loop as above, then an exit after 5 taken -> trip=5, conf=0, and LD_en=0 on the next fetch.
- Alias: PC 0x100 is trained with conf=3; a taken backward branch at 0x500 (same idx, different tag) must age it.
  - 1st event -> conf=2, no allocation; 3 further events -> allocation.
  - The old tag then misses with LD_en=0.
- Forward branch (PC_destination > PC_EX) resolved 10 times -> no table change and LD_en stays 0.
- Clear behaviour, with defaults:
  - clear_req pulse -> busy=1 for exactly 64 cycles, and all entries miss afterwards.
  - A branch resolve during busy is dropped.
  - rst=0 in cycle 10 of the walk -> busy=0 on the next cycle.
